cmd_controller: RTL and testbench

CMD_CONTROLLER -- requirements
Module: cmd_controller

---
 rtl/cmd_controller.sv | 161 ++++++++++++++++
 tb/tb_cmd_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_controller.sv
// Command controller: decodes READ/WRITE/KEY commands and sequences
// slot reads, write-data assembly with commit, and key-slice strobes.
module cmd_controller #(
    parameter int WORD_W         = 32,
    parameter int MAX_WORDS      = 14,
    parameter int N_SLOTS        = 16,
    parameter int N_KEY          = 6,
    parameter int MAX_KEY_ROUNDS = 64,
    localparam int SLICE_W       = $clog2(MAX_KEY_ROUNDS),
    localparam int SLOT_W        = $clog2(N_SLOTS),
    localparam int BUS_W         = WORD_W * MAX_WORDS
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WORD_W-1:0]  cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WORD_W-1:0]  rsp_data,
    input  logic [BUS_W-1:0]   dataOut,
    output logic [SLOT_W-1:0]  selectRead,
    output logic [BUS_W-1:0]   writeBus,
    output logic [N_SLOTS-1:0] writeEnable,
    output logic [N_KEY-1:0]   writeEnableKey,
    output logic [SLICE_W-1:0] sliceSelector,
    output logic               busy,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_COMMIT,
        S_KEY
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_cnt;
    logic [7:0]          r_len;
    logic [SLOT_W-1:0]   r_slot;
    logic [BUS_W-1:0]    r_wbus;
    logic                r_err;

    logic [1:0]          w_op;
    logic [7:0]          w_len;
    logic [3:0]          w_slot;
    logic                w_legal;
    logic                w_accept;
    logic                w_last;
    logic                w_unused_bits;

    assign w_op          = cmd_data[31:30];
    assign w_len         = cmd_data[15:8];
    assign w_slot        = cmd_data[3:0];
    assign w_unused_bits = ^{cmd_data[29:16], cmd_data[7:4]};

    always_comb begin
        w_legal = 1'b0;
        if (w_op != 2'b11 && w_len != 8'd0) begin
            if (w_op == 2'b10)
                w_legal = int'(w_slot) < N_KEY
                       && int'(w_len) <= MAX_KEY_ROUNDS;
            else
                w_legal = int'(w_slot) < N_SLOTS
                       && int'(w_len) <= MAX_WORDS;
        end
    end

    assign w_accept = (r_state == S_IDLE) && cmd_valid && w_legal;
    assign w_last   = (r_cnt == r_len - 8'd1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (1'b1)
                        (w_op == 2'b00): w_next = S_READ;
                        (w_op == 2'b01): w_next = S_WRITE;
                        default:         w_next = S_KEY;
                    endcase
                end
            end
            S_READ:   if (rsp_ready && w_last) w_next = S_IDLE;
            S_WRITE:  if (cmd_valid && w_last) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            S_KEY:    if (w_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_slot <= '0;
            r_wbus <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && cmd_valid && !w_legal;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_len  <= w_len;
                        r_slot <= SLOT_W'(w_slot);
                        r_cnt  <= '0;
                        // Unwritten words must read back as zero
                        if (w_op == 2'b01) r_wbus <= '0;
                    end
                end
                S_READ: begin
                    if (rsp_ready) r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
                end
                S_WRITE: begin
                    if (cmd_valid) begin
                        for (int i = 0; i < MAX_WORDS; i++)
                            if (r_cnt == 8'(i))
                                r_wbus[i*WORD_W +: WORD_W] <= cmd_data;
                        r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
                    end
                end
                S_KEY: r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < MAX_WORDS; i++)
            if (r_cnt == 8'(i)) rsp_data = dataOut[i*WORD_W +: WORD_W];
    end

    always_comb begin
        writeEnable    = '0;
        writeEnableKey = '0;
        for (int i = 0; i < N_SLOTS; i++)
            if (r_state == S_COMMIT && r_slot == SLOT_W'(i))
                writeEnable[i] = 1'b1;
        for (int i = 0; i < N_KEY; i++)
            if (r_state == S_KEY && r_slot == SLOT_W'(i))
                writeEnableKey[i] = 1'b1;
    end

    assign sliceSelector = (r_state == S_KEY) ? r_cnt[SLICE_W-1:0] : '0;
    assign cmd_ready     = (r_state == S_IDLE) || (r_state == S_WRITE);
    assign rsp_valid     = (r_state == S_READ);
    assign busy          = (r_state != S_IDLE);
    assign error         = r_err;
    assign selectRead    = r_slot;
    assign writeBus      = r_wbus;

endmodule

// File: tb/tb_cmd_controller.sv
// Directed bench for cmd_controller: read with stall, write/commit,
// key schedule, rejected commands and mid-write reset.
module tb_cmd_controller;

    logic         clock;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic [447:0] dataOut;
    logic [3:0]   selectRead;
    logic [447:0] writeBus;
    logic [15:0]  writeEnable;
    logic [5:0]   writeEnableKey;
    logic [5:0]   sliceSelector;
    logic         busy;
    logic         error;

    int checks = 0;
    int errors = 0;

    cmd_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .dataOut        (dataOut),
        .selectRead     (selectRead),
        .writeBus       (writeBus),
        .writeEnable    (writeEnable),
        .writeEnableKey (writeEnableKey),
        .sliceSelector  (sliceSelector),
        .busy           (busy),
        .error          (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [1:0] op,
                                       input logic [7:0] len,
                                       input logic [3:0] slot);
        return {op, 14'b0, len, 4'b0, slot};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] wb(input int i);
        return writeBus[i*32 +: 32];
    endfunction

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 14; i++)
            dataOut[i*32 +: 32] = 32'hA0A0_0000 + 32'(i);

        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_we", 64'(writeEnable), 64'd0);
        chk("rst_wek", 64'(writeEnableKey), 64'd0);
        chk("rst_slice", 64'(sliceSelector), 64'd0);
        chk("rst_sel", 64'(selectRead), 64'd0);
        chk("rst_err", 64'(error), 64'd0);
        chk("rst_bus", 64'(|writeBus), 64'd0);
        reset_n = 1'b1;

        // READ slot 3 len 4 with a 2-cycle stall on word 1
        tick();
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b00, 8'd4, 4'd3);
        #1 chk("rd_acc_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("rd_busy", 64'(busy), 64'd1);
        chk("rd_sel", 64'(selectRead), 64'd3);
        chk("rd_rspv", 64'(rsp_valid), 64'd1);
        chk("rd_ready0", 64'(cmd_ready), 64'd0);
        chk("rd_w0", 64'(rsp_data), 64'hA0A0_0000);
        rsp_ready = 1'b1;
        tick();
        chk("rd_w1", 64'(rsp_data), 64'hA0A0_0001);
        rsp_ready = 1'b0;
        tick();
        chk("rd_w1_st1", 64'(rsp_data), 64'hA0A0_0001);
        tick();
        chk("rd_w1_st2", 64'(rsp_data), 64'hA0A0_0001);
        rsp_ready = 1'b1;
        tick();
        chk("rd_w2", 64'(rsp_data), 64'hA0A0_0002);
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b01, 8'd1, 4'd0);
        #1 chk("rd_ign_ready", 64'(cmd_ready), 64'd0);
        tick();
        cmd_valid = 1'b0;
        chk("rd_w3", 64'(rsp_data), 64'hA0A0_0003);
        chk("rd_w3_v", 64'(rsp_valid), 64'd1);
        tick();
        rsp_ready = 1'b0;
        chk("rd_done_busy", 64'(busy), 64'd0);
        chk("rd_done_rspv", 64'(rsp_valid), 64'd0);
        chk("rd_no_queue_we", 64'(writeEnable), 64'd0);

        // WRITE slot 5 len 2, issued on first IDLE cycle
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b01, 8'd2, 4'd5);
        #1 chk("wr_acc_ready", 64'(cmd_ready), 64'd1);
        tick();
        cmd_data = 32'hDEAD_BEEF;
        #1;
        chk("wr_s0_busy", 64'(busy), 64'd1);
        chk("wr_s0_ready", 64'(cmd_ready), 64'd1);
        chk("wr_s0_we", 64'(writeEnable), 64'd0);
        tick();
        cmd_data = 32'h1234_5678;
        #1 chk("wr_s1_we", 64'(writeEnable), 64'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("wr_commit_we", 64'(writeEnable), 64'h0020);
        chk("wr_commit_rdy", 64'(cmd_ready), 64'd0);
        chk("wr_word0", 64'(wb(0)), 64'hDEAD_BEEF);
        chk("wr_word1", 64'(wb(1)), 64'h1234_5678);
        chk("wr_upper0", 64'(|writeBus[447:64]), 64'd0);
        tick();
        chk("wr_post_we", 64'(writeEnable), 64'd0);
        chk("wr_post_busy", 64'(busy), 64'd0);
        chk("wr_hold1", 64'(wb(1)), 64'h1234_5678);

        // WRITE slot 1 len 1: previous bus content must be cleared
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b01, 8'd1, 4'd1);
        tick();
        chk("wr2_clr0", 64'(wb(0)), 64'd0);
        chk("wr2_clr1", 64'(wb(1)), 64'd0);
        cmd_data = 32'h0000_0055;
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("wr2_we", 64'(writeEnable), 64'h0002);
        chk("wr2_word0", 64'(wb(0)), 64'h55);
        chk("wr2_word1", 64'(wb(1)), 64'd0);
        tick();

        // KEY slot 2 len 10
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b10, 8'd10, 4'd2);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("key_wek", 64'(writeEnableKey), 64'b000100);
            chk("key_slice", 64'(sliceSelector), 64'(i));
            chk("key_ready", 64'(cmd_ready), 64'd0);
            tick();
        end
        chk("key_end_wek", 64'(writeEnableKey), 64'd0);
        chk("key_end_slice", 64'(sliceSelector), 64'd0);
        chk("key_end_busy", 64'(busy), 64'd0);

        // Rejected commands
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b11, 8'd1, 4'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("bad_op_err", 64'(error), 64'd1);
        chk("bad_op_busy", 64'(busy), 64'd0);
        tick();
        chk("bad_op_pulse", 64'(error), 64'd0);
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b00, 8'd15, 4'd0);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("bad_len_err", 64'(error), 64'd1);
        chk("bad_len_busy", 64'(busy), 64'd0);
        chk("bad_len_rspv", 64'(rsp_valid), 64'd0);
        tick();
        chk("bad_len_pulse", 64'(error), 64'd0);
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b10, 8'd1, 4'd7);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("bad_key_err", 64'(error), 64'd1);
        chk("bad_key_busy", 64'(busy), 64'd0);
        chk("bad_key_wek", 64'(writeEnableKey), 64'd0);
        tick();
        chk("bad_key_pulse", 64'(error), 64'd0);
        chk("bad_key_wek2", 64'(writeEnableKey), 64'd0);

        // Reset during WRITE word 1 of 3
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b01, 8'd3, 4'd4);
        tick();
        cmd_data = 32'h1111_1111;
        tick();
        cmd_data = 32'h2222_2222;
        chk("mid_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_bus", 64'(|writeBus), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_we", 64'(writeEnable), 64'd0);
        cmd_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_we", 64'(writeEnable), 64'd0);
        chk("post_rst_rdy", 64'(cmd_ready), 64'd1);
        chk("post_rst_bus", 64'(|writeBus), 64'd0);
        cmd_valid = 1'b1;
        cmd_data  = mk(2'b00, 8'd1, 4'd3);
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        chk("post_rd_v", 64'(rsp_valid), 64'd1);
        chk("post_rd_sel", 64'(selectRead), 64'd3);
        chk("post_rd_data", 64'(rsp_data), 64'hA0A0_0000);
        tick();
        rsp_ready = 1'b0;
        chk("post_rd_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
